bcd_word_checker: RTL
=====================

# bcd_word_checker

Sequential, parametrised BCD input stage. Accepts one 4-bit code digit per handshake, checks each digit for validity in the selected code (8421 BCD or excess-3), and assembles NUM_DIGITS digits into a word. The word is presented on a ready/valid output with a per-digit error mask and a running error count. It sits between keypad/switch input logic and the BCD arithmetic and display blocks.

## Interface
- NUM_DIGITS, 4, digits per assembled word (≥1).
- CODE, 0, input code: 0 = 8421 BCD (valid 0–9), 1 = excess-3 (valid 3–12).
- CNT_W, 8, width of the saturating error counter.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_digit is valid.
- in_ready  out  1  block accepts a digit this cycle.
- in_digit  in  4  code digit.
- out_valid  out  1  assembled word available.
- out_ready  in  1  consumer accepts the word.
- out_word  out  4*NUM_DIGITS  converted 8421 digits; the first accepted digit is in the most-significant nibble.
- out_err  out  1  OR of out_err_mask.
- out_err_mask  out  NUM_DIGITS  bit i set means nibble i of out_word came from an invalid digit.
- err_count  out  CNT_W  invalid digits accepted since reset/clear; saturates.
- clear  in  1  synchronous clear of err_count.

## Operation
- FSM has two states: COLLECT and HOLD. Reset state is COLLECT.
- Digit acceptance:
  - An accept occurs when in_valid & in_ready.
  - In COLLECT, in_ready = 1.
  - In HOLD, in_ready = 0, and the block never drops or overwrites a held word.
- Each accepted digit:
  - Shifts into the word register from the LSB side, so earlier digits move toward the MSB.
  - Increments the digit index.
- Validity and conversion:
  - CODE = 0: valid iff digit ≤ 9, and the stored value is the digit itself.
  - CODE = 1: valid iff 3 ≤ digit ≤ 12, and the stored value is digit − 3.
  - Invalid digits are stored as 4'hF, with the matching mask bit set.
- Word completion: when the NUM_DIGITS-th digit is accepted, the index wraps to 0 and the FSM goes to HOLD.
- In HOLD, out_valid = 1. When out_valid & out_ready, the FSM returns to COLLECT, and out_word and the mask are cleared to 0.
- err_count:
  - Increments by 1 for each accepted invalid digit and saturates at 2^CNT_W − 1.
  - clear forces it to 0. clear wins over a same-cycle increment.
  - clear does not affect the FSM or the word.
- Reset values: in_ready = 1 (while rst is deasserted), out_valid = 0, out_word = 0, out_err_mask = 0, out_err = 0, err_count = 0, index = 0.
- Reset mid-word: the partial word is discarded immediately (asynchronous reset).

## Timing
- Accepted-digit throughput is 1 digit/cycle in COLLECT.
- out_valid rises on the clock edge that accepts the last digit. Latency is 0 cycles of additional delay after the final accept.
- The word, mask and out_err are stable while out_valid = 1.
- The earliest next accept is the cycle after the output handshake. A full word of N digits with out_ready tied high therefore takes N + 1 cycles.
- out_valid stays high indefinitely while out_ready = 0. in_ready stays low for that whole period.
- in_digit is sampled only on accept. Its value when in_valid = 0 is ignored.
- All outputs are registered, except in_ready (decoded from state) and out_err (OR of the registered mask).

## Structure
- Package bcd_pkg holds:
  - the state enum (COLLECT, HOLD);
  - the CODE_8421 and CODE_XS3 constants;
  - the INVALID_NIBBLE = 4'hF constant.
- Sub-module bcd_digit_check holds the combinational validity/convert logic, parametrised by CODE:
  - inputs: 4-bit digit;
  - outputs: valid and 4-bit converted value.
  - It is reused by the BCD adder block.
- Top level holds the FSM, shift register, mask register, index counter and error counter.

## Test plan
- CODE = 0, N = 4, out_ready = 1: accept 1, 9, 0, 5 back-to-back → out_valid for 1 cycle; out_word = 16'h1905, mask = 0, err_count = 0; in_ready low for exactly that cycle.
- CODE = 0: accept 3, A, 7, F → out_word = 16'h3F7F, mask = 4'b0101, out_err = 1, err_count = 2.
- CODE = 1: accept 3, C, 8, 2 → out_word = 16'h095F, mask = 4'b0001, err_count = 1.
- Backpressure: hold out_ready = 0 for 5 cycles after a full word while driving in_valid = 1 → in_ready = 0 throughout, word unchanged, no digit lost; after the handshake the next word assembles correctly.
- CNT_W = 2: feed 5 invalid digits → err_count sticks at 3. Then assert clear in the same cycle as an invalid accept → err_count = 0.
- Assert rst after 2 of 4 digits → all outputs return to reset values immediately. Then 4 new digits produce a word containing only the new digits.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD input stage and the blocks that reuse
// its digit checker: FSM state encoding, input-code selectors and the
// nibble value used to mark an invalid digit.
package bcd_pkg;

    // Word assembler states: gathering digits, or presenting a full word.
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Input code selectors for the CODE parameter.
    localparam int CODE_8421 = 0;
    localparam int CODE_XS3  = 1;

    // Value stored in place of a digit that is not legal in the selected code.
    localparam logic [3:0] INVALID_NIBBLE = 4'hF;

    // Excess-3 carries a fixed bias of three over the plain 8421 value.
    localparam logic [3:0] XS3_BIAS = 4'd3;

    // Legal-code test shared by the checker and any block that only needs
    // the validity bit without the converted value.
    function automatic logic code_digit_valid(input int code, input logic [3:0] digit);
        logic ok;
        ok = 1'b0;
        if (code == CODE_XS3) begin
            ok = (digit >= XS3_BIAS) && (digit <= 4'd12);
        end else begin
            ok = (digit <= 4'd9);
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational validity check and conversion of one code digit into its
// 8421 value. Illegal digits come out as INVALID_NIBBLE with valid low, so
// a consumer can store the value unconditionally and keep the flag apart.
module bcd_digit_check
    import bcd_pkg::*;
#(
    parameter int CODE = CODE_8421
) (
    input  logic [3:0] digit,
    output logic       valid,
    output logic [3:0] value
);

    // Decide legality for the selected code, then remove the bias if any.
    always_comb begin
        valid = code_digit_valid(CODE, digit);
        value = INVALID_NIBBLE;
        if (valid) begin
            if (CODE == CODE_XS3) begin
                value = digit - XS3_BIAS;
            end else begin
                value = digit;
            end
        end
    end

endmodule

// File: rtl/bcd_word_checker.sv
// BCD input stage: accepts one code digit per input handshake, checks and
// converts it, and assembles NUM_DIGITS digits into a word that is offered
// on a ready/valid output together with a per-digit error mask.
//
// Handshake rules (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. in_ready is high only while
// collecting, so a finished word is never overwritten; out_valid is high
// only while holding, and the held word, mask and out_err do not change
// until the consumer takes the word.
module bcd_word_checker
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CODE       = CODE_8421,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_digit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] out_word,
    output logic                    out_err,
    output logic [NUM_DIGITS-1:0]   out_err_mask,
    output logic [CNT_W-1:0]        err_count,
    input  logic                    clear
);

    localparam int WORD_W = 4 * NUM_DIGITS;
    // A single-digit word still gets a one-bit index so the port widths
    // stay legal; it simply wraps on every accept.
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WORD_W-1:0]  word_q;
    logic [NUM_DIGITS-1:0] mask_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic               out_fire;
    logic               last_digit;
    logic               dig_valid;
    logic [3:0]         dig_value;

    bcd_digit_check #(
        .CODE (CODE)
    ) u_digit_check (
        .digit (in_digit),
        .valid (dig_valid),
        .value (dig_value)
    );

    // Handshake decode straight from the state register.
    always_comb begin
        in_ready   = (state_q == COLLECT);
        out_valid  = (state_q == HOLD);
        accept     = in_valid && in_ready;
        out_fire   = out_valid && out_ready;
        last_digit = (idx_q == LAST_IDX);
    end

    // FSM: enter HOLD on the edge that takes the final digit, leave it on
    // the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept && last_digit) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    // Digit position within the word being collected; wraps on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else if (accept) begin
            if (last_digit) begin
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Word and mask shift in from the LSB side so the first digit ends up
    // in the top nibble; both are zeroed once the consumer takes the word.
    // The two events are exclusive since accepts only happen in COLLECT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            mask_q <= '0;
        end else if (accept) begin
            word_q <= (word_q << 4) | WORD_W'(dig_value);
            mask_q <= (mask_q << 1) | NUM_DIGITS'(!dig_valid);
        end else if (out_fire) begin
            word_q <= '0;
            mask_q <= '0;
        end
    end

    // Saturating count of invalid digits accepted; clear has priority and
    // touches nothing else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (accept && !dig_valid && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Registered outputs plus the OR-reduced error flag.
    always_comb begin
        out_word     = word_q;
        out_err_mask = mask_q;
        out_err      = |mask_q;
        err_count    = cnt_q;
    end

endmodule
